// File: rtl/z80bd_pkg.sv
// Shared definitions for the Z80BD CPLD: I/O port map, interrupt source
// indices, interrupt-controller state encoding and the source priority encoder.
package z80bd_pkg;

  // Port addresses in the 8-bit I/O space (shared with mapper / sysregs)
  localparam logic [7:0] PORT_INT_MASK = 8'h30;
  localparam logic [7:0] PORT_INT_PEND = 8'h31;
  localparam logic [7:0] PORT_INT_VEC  = 8'h32;
  localparam logic [7:0] PORT_TIMER    = 8'h33;

  // Interrupt sources; lower index wins
  localparam logic [1:0] SRC_TIMER = 2'd0;
  localparam logic [1:0] SRC_UART  = 2'd1;
  localparam logic [1:0] SRC_EXT0  = 2'd2;
  localparam logic [1:0] SRC_EXT1  = 2'd3;

  // Register reset values
  localparam logic [3:0] MASK_RST   = 4'h0;
  localparam logic [4:0] VBASE_RST  = 5'b11100;
  localparam logic [7:0] RELOAD_RST = 8'd19;   // 20 ms -> 50 Hz

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } int_state_t;

  function automatic logic [1:0] prio_enc(input logic [3:0] req);
    if (req[0])      return SRC_TIMER;
    else if (req[1]) return SRC_UART;
    else if (req[2]) return SRC_EXT0;
    else             return SRC_EXT1;
  endfunction

endpackage

// File: rtl/z80bd_tick_timer.sv
// Periodic interrupt timer: a 1 ms prescaler feeding a millisecond down-counter.
// Ports:
//   i_clk      - CLK_24MHz
//   i_reset    - synchronous, active-high
//   i_restart  - clears the prescaler and reloads the ms counter from i_reload
//   i_reload   - period in ms minus 1
//   o_tick     - one-cycle pulse every (i_reload+1)*PRESCALE cycles
module z80bd_tick_timer import z80bd_pkg::*; #(
  parameter int PRESCALE = 24000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_restart,
  input  logic [7:0] i_reload,
  output logic       o_tick
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic [7:0]    r_ms;
  logic          w_ms_stb;

  assign w_ms_stb = (r_pre == PRE_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pre  <= '0;
      r_ms   <= RELOAD_RST;
      o_tick <= 1'b0;
    end else if (i_restart) begin
      r_pre  <= '0;
      r_ms   <= i_reload;
      o_tick <= 1'b0;
    end else begin
      o_tick <= 1'b0;
      if (w_ms_stb) begin
        r_pre <= '0;
        // reload+1 ms strobes per tick, so the period is exact
        if (r_ms == 8'd0) begin
          o_tick <= 1'b1;
          r_ms   <= i_reload;
        end else begin
          r_ms <= r_ms - 8'd1;
        end
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/z80bd_int_ctrl.sv
// Z80BD interrupt controller: drives CPU INT from timer, UART and two external
// request pins, and supplies an IM2 vector during interrupt acknowledge.
// Ports:
//   i_clk_24mhz, i_reset           - sole clock, synchronous active-high reset
//   i_iorq_n/i_m1_n/i_rd_n/i_wr_n  - raw Z80 strobes (asynchronous)
//   i_a_l, i_d_in                  - CPU A[7:0] and data bus input side
//   o_d_out, o_d_oe                - read data / vector and tristate enable
//   i_irq_uart                     - 16550 INTR, active-high level
//   i_irq_ext[1:0]                 - spare requests, rising edge
//   o_int_n                        - CPU INT, active-low
//
// state | meaning
// IDLE  | no request outstanding; pick highest-priority enabled pending source
// REQ   | INT asserted, cur_src frozen until acknowledge starts
// ACK   | INT released, waiting for the acknowledge cycle to end
module z80bd_int_ctrl import z80bd_pkg::*; #(
  parameter logic [7:0] INT_MASK_PORT = PORT_INT_MASK,
  parameter logic [7:0] INT_PEND_PORT = PORT_INT_PEND,
  parameter logic [7:0] INT_VEC_PORT  = PORT_INT_VEC,
  parameter logic [7:0] TIMER_PORT    = PORT_TIMER,
  parameter int         PRESCALE      = 24000
) (
  input  logic       i_clk_24mhz,
  input  logic       i_reset,
  input  logic       i_iorq_n,
  input  logic       i_m1_n,
  input  logic       i_rd_n,
  input  logic       i_wr_n,
  input  logic [7:0] i_a_l,
  input  logic [7:0] i_d_in,
  output logic [7:0] o_d_out,
  output logic       o_d_oe,
  input  logic       i_irq_uart,
  input  logic [1:0] i_irq_ext,
  output logic       o_int_n
);

  // Synchroniser bits: {ext1, ext0, uart, wr_n, m1_n, iorq_n}.
  // rd_n only gates the combinational read path, so it is not synchronised.
  localparam logic [5:0] SYNC_RST = 6'b000111;

  logic [5:0] r_sync1, r_sync2;
  logic       r_iowr_d, r_ack_d;
  logic [1:0] r_ext_d, r_ext_rise;
  logic [3:0] r_mask;
  logic [4:0] r_vec_base;
  logic [7:0] r_reload;
  logic       r_pend_tmr;
  logic [1:0] r_pend_ext;
  int_state_t r_state;
  logic [1:0] r_cur_src;
  logic       r_int_n;

  logic       w_iorq_s, w_m1_s, w_wr_s, w_uart_s;
  logic [1:0] w_ext_s;
  logic       w_iowr_s, w_ack_s, w_wr_stb, w_ack_rise, w_ack_clr;
  logic       w_wr_mask, w_wr_pend, w_wr_vec, w_wr_timer;
  logic       w_clr_tmr, w_tick;
  logic [1:0] w_clr_ext;
  logic [3:0] w_pend, w_req;
  logic [7:0] w_reload_val;

  assign w_iorq_s = r_sync2[0];
  assign w_m1_s   = r_sync2[1];
  assign w_wr_s   = r_sync2[2];
  assign w_uart_s = r_sync2[3];
  assign w_ext_s  = r_sync2[5:4];

  assign w_iowr_s   = ~w_iorq_s & ~w_wr_s;
  assign w_ack_s    = ~w_iorq_s & ~w_m1_s;
  assign w_wr_stb   = w_iowr_s & ~r_iowr_d;
  assign w_ack_rise = w_ack_s & ~r_ack_d;
  assign w_ack_clr  = (r_state == ST_REQ) & w_ack_rise;

  assign w_wr_mask  = w_wr_stb & (i_a_l == INT_MASK_PORT);
  assign w_wr_pend  = w_wr_stb & (i_a_l == INT_PEND_PORT);
  assign w_wr_vec   = w_wr_stb & (i_a_l == INT_VEC_PORT);
  assign w_wr_timer = w_wr_stb & (i_a_l == TIMER_PORT);

  // UART pending is the synchronised level itself; only edge sources latch.
  assign w_pend = {r_pend_ext, w_uart_s, r_pend_tmr};
  assign w_req  = w_pend & r_mask;

  assign w_clr_tmr    = (w_wr_pend & i_d_in[0]) | (w_ack_clr & (r_cur_src == SRC_TIMER));
  assign w_clr_ext[0] = (w_wr_pend & i_d_in[2]) | (w_ack_clr & (r_cur_src == SRC_EXT0));
  assign w_clr_ext[1] = (w_wr_pend & i_d_in[3]) | (w_ack_clr & (r_cur_src == SRC_EXT1));

  // New reload value reaches the timer in the same cycle as its restart
  assign w_reload_val = w_wr_timer ? i_d_in : r_reload;

  z80bd_tick_timer #(.PRESCALE(PRESCALE)) u_timer (
    .i_clk     (i_clk_24mhz),
    .i_reset   (i_reset),
    .i_restart (w_wr_timer),
    .i_reload  (w_reload_val),
    .o_tick    (w_tick)
  );

  always_ff @(posedge i_clk_24mhz) begin
    if (i_reset) begin
      r_sync1    <= SYNC_RST;
      r_sync2    <= SYNC_RST;
      r_iowr_d   <= 1'b0;
      r_ack_d    <= 1'b0;
      r_ext_d    <= 2'b00;
      r_ext_rise <= 2'b00;
    end else begin
      r_sync1    <= {i_irq_ext, i_irq_uart, i_wr_n, i_m1_n, i_iorq_n};
      r_sync2    <= r_sync1;
      r_iowr_d   <= w_iowr_s;
      r_ack_d    <= w_ack_s;
      r_ext_d    <= w_ext_s;
      r_ext_rise <= w_ext_s & ~r_ext_d;
    end
  end

  always_ff @(posedge i_clk_24mhz) begin
    if (i_reset) begin
      r_mask     <= MASK_RST;
      r_vec_base <= VBASE_RST;
      r_reload   <= RELOAD_RST;
      r_pend_tmr <= 1'b0;
      r_pend_ext <= 2'b00;
    end else begin
      if (w_wr_mask)  r_mask     <= i_d_in[3:0];
      if (w_wr_vec)   r_vec_base <= i_d_in[7:3];
      if (w_wr_timer) r_reload   <= i_d_in;
      // set is OR-ed after the clear so a coincident set wins
      r_pend_tmr <= (r_pend_tmr & ~w_clr_tmr) | w_tick;
      r_pend_ext <= (r_pend_ext & ~w_clr_ext) | r_ext_rise;
    end
  end

  always_ff @(posedge i_clk_24mhz) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cur_src <= SRC_TIMER;
      r_int_n   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (|w_req) begin
          r_cur_src <= prio_enc(w_req);
          r_state   <= ST_REQ;
          r_int_n   <= 1'b0;
        end
        // masking/clearing cur_src here does not withdraw INT: the CPU
        // still gets this vector (spurious interrupt)
        ST_REQ: if (w_ack_rise) begin
          r_state <= ST_ACK;
          r_int_n <= 1'b1;
        end
        ST_ACK: if (!w_ack_s) r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_int_n <= 1'b1;
        end
      endcase
    end
  end

  assign o_int_n = r_int_n;

  // Bus drive follows the raw strobes; cur_src is stable through REQ/ACK
  always_comb begin
    o_d_oe  = 1'b0;
    o_d_out = 8'h00;
    if (~i_m1_n & ~i_iorq_n) begin
      o_d_oe  = 1'b1;
      o_d_out = {r_vec_base, r_cur_src, 1'b0};
    end else if (~i_iorq_n & ~i_rd_n) begin
      case (i_a_l)
        INT_MASK_PORT: begin o_d_oe = 1'b1; o_d_out = {4'b0000, r_mask}; end
        INT_PEND_PORT: begin o_d_oe = 1'b1; o_d_out = {4'b0000, w_pend}; end
        INT_VEC_PORT:  begin o_d_oe = 1'b1; o_d_out = {r_vec_base, 3'b000}; end
        TIMER_PORT:    begin o_d_oe = 1'b1; o_d_out = r_reload; end
        default:       begin o_d_oe = 1'b0; o_d_out = 8'h00; end
      endcase
    end
  end

endmodule
